// File: rtl/uart_rx_loader_pkg.sv
// Shared constants for the UART program loader: bit timing default and FSM state encodings.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// CLK_PER_HALF_BIT_DEFAULT is also used by the matching UART transmitter, so both ends agree
// on the baud rate without separate configuration.
package uart_rx_loader_pkg;

  // 115200 baud from a ~100 MHz core clock.
  localparam int CLK_PER_HALF_BIT_DEFAULT = 435;

  // Bit receiver states
  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  // Loader states
  localparam logic [1:0] L_LEN    = 2'd0;
  localparam logic [1:0] L_DATA   = 2'd1;
  localparam logic [1:0] L_DONE   = 2'd2;

endpackage

// File: rtl/uart_rx_loader_rx.sv
// UART 8N1 bit receiver: 2-flop synchroniser plus start/data/stop bit FSM.
// Latency: byte_valid 2 + 19*CLK_PER_HALF_BIT cycles after the start-bit falling edge.
// Backpressure: none; byte_valid is a 1-cycle pulse that must be consumed immediately.
//
// Ports:
//   clk, rstn         clock, async active-low reset
//   rxd               raw serial input (idle high, asynchronous to clk)
//   byte_valid        1-cycle pulse, byte_data holds a correctly framed byte
//   byte_data         last good byte
//   ferr              sticky, set when a stop bit is sampled low
module uart_rx
  import uart_rx_loader_pkg::*;
#(
  parameter int CLK_PER_HALF_BIT = CLK_PER_HALF_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rxd,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       ferr
);

  localparam int TW = $clog2(2 * CLK_PER_HALF_BIT);
  localparam logic [TW-1:0] HALF_END = TW'(CLK_PER_HALF_BIT - 1);
  localparam logic [TW-1:0] BIT_END  = TW'(2 * CLK_PER_HALF_BIT - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          w_rxs;
  logic [1:0]    r_state;
  logic [TW-1:0] r_timer;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_byte_vld;
  logic [7:0]    r_byte_dat;
  logic          r_ferr;

  // Synchroniser resets to 1 so a reset never looks like a start bit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rxd;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rxs = r_sync2;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= RX_IDLE;
      r_timer    <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_byte_vld <= 1'b0;
      r_byte_dat <= '0;
      r_ferr     <= 1'b0;
    end else begin
      r_byte_vld <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          if (!w_rxs) begin
            r_state <= RX_START;
            r_timer <= '0;
          end
        end
        RX_START: begin
          // Re-check the line mid start bit; a high here was a glitch.
          if (r_timer == HALF_END) begin
            r_timer   <= '0;
            r_bit_idx <= '0;
            r_state   <= w_rxs ? RX_IDLE : RX_DATA;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        RX_DATA: begin
          if (r_timer == BIT_END) begin
            r_timer <= '0;
            r_shift <= {w_rxs, r_shift[7:1]};
            if (r_bit_idx == 3'd7) begin
              r_state <= RX_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        RX_STOP: begin
          // Return to IDLE at the mid-stop sample so short stop bits and
          // back-to-back frames are accepted.
          if (r_timer == BIT_END) begin
            r_timer <= '0;
            r_state <= RX_IDLE;
            if (w_rxs) begin
              r_byte_vld <= 1'b1;
              r_byte_dat <= r_shift;
            end else begin
              r_ferr <= 1'b1;
            end
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

  assign byte_valid = r_byte_vld;
  assign byte_data  = r_byte_dat;
  assign ferr       = r_ferr;

endmodule

// File: rtl/uart_rx_loader.sv
// UART program loader: receives a word count then little-endian words, writes instruction memory.
// Latency: we pulses 1 cycle after byte_valid of the 4th byte of each word.
// Backpressure: none; memory must accept a write every cycle that we is high.
//
// Ports:
//   clk, rstn            clock, async active-low reset
//   rxd                  serial input
//   byte_valid/byte_data received byte strobe and value
//   we/waddr/wdata       instruction memory write port
//   busy                 loading in progress (first header byte until done)
//   done                 sticky, all words written
//   ferr                 sticky framing error
module uart_rx_loader
  import uart_rx_loader_pkg::*;
#(
  parameter int CLK_PER_HALF_BIT = CLK_PER_HALF_BIT_DEFAULT,
  parameter int ADDR_W           = 15
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              rxd,
  output logic              byte_valid,
  output logic [7:0]        byte_data,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              ferr
);

  logic              w_byte_vld;
  logic [7:0]        w_byte;
  logic              w_ferr;

  logic [1:0]        r_lstate;
  logic [1:0]        r_idx;
  logic [31:0]       r_count;
  logic [31:0]       r_nwr;
  logic [31:0]       r_word;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [31:0]       r_wdata;
  logic              r_busy;
  logic              r_done;

  uart_rx #(
    .CLK_PER_HALF_BIT (CLK_PER_HALF_BIT)
  ) u_rx (
    .clk        (clk),
    .rstn       (rstn),
    .rxd        (rxd),
    .byte_valid (w_byte_vld),
    .byte_data  (w_byte),
    .ferr       (w_ferr)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_lstate <= L_LEN;
      r_idx    <= '0;
      r_count  <= '0;
      r_nwr    <= '0;
      r_word   <= '0;
      r_we     <= 1'b0;
      r_waddr  <= '0;
      r_wdata  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_we <= 1'b0;
      // Address moves on after the write so waddr is stable during we.
      if (r_we) begin
        r_waddr <= r_waddr + ADDR_W'(1);
      end
      if (w_byte_vld) begin
        case (r_lstate)
          L_LEN: begin
            r_busy                    <= 1'b1;
            r_count[{r_idx, 3'b000} +: 8] <= w_byte;
            r_idx                     <= r_idx + 2'd1;
            if (r_idx == 2'd3) begin
              // Full 32-bit compare using the byte arriving now.
              if ({w_byte, r_count[23:0]} == 32'd0) begin
                r_lstate <= L_DONE;
                r_done   <= 1'b1;
                r_busy   <= 1'b0;
              end else begin
                r_lstate <= L_DATA;
              end
            end
          end
          L_DATA: begin
            r_word[{r_idx, 3'b000} +: 8] <= w_byte;
            r_idx                        <= r_idx + 2'd1;
            if (r_idx == 2'd3) begin
              r_we    <= 1'b1;
              r_wdata <= {w_byte, r_word[23:0]};
              r_nwr   <= r_nwr + 32'd1;
              if (r_nwr + 32'd1 == r_count) begin
                r_lstate <= L_DONE;
                r_done   <= 1'b1;
                r_busy   <= 1'b0;
              end
            end
          end
          default: ; // L_DONE: bytes still reported, nothing written
        endcase
      end
    end
  end

  assign byte_valid = w_byte_vld;
  assign byte_data  = w_byte;
  assign ferr       = w_ferr;
  assign we         = r_we;
  assign waddr      = r_waddr;
  assign wdata      = r_wdata;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule
